// File: rtl/upcount_sched.sv
`default_nettype none
// ============================================================================
// Module      : upcount_sched
// Description : Round-robin scheduler sharing one upcounter among R requesters
//               to time programmable delay intervals.
// Revision    : 1.0 - initial release
// ============================================================================
module upcount_sched #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [R-1:0]     req,
    input  logic [R*N-1:0]   dly,
    output logic [R-1:0]     gnt,
    output logic [R-1:0]     done,
    output logic             busy,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [N-1:0]     cnt_val
);

    localparam int IW = $clog2(R);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [N-1:0]    tgt_q;

    logic [IW-1:0]   win_d;
    logic [N-1:0]    tgt_d;
    logic            found;
    logic [IW-1:0]   cand;
    logic [R-1:0]    own;

    // Search starts one past the last owner so the previous winner ranks last.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= R; k++) begin
            cand = IW'((int'(ptr_q) + k) % R);
            if (!found && req[cand]) begin
                win_d = cand;
                found = 1'b1;
            end
        end
        tgt_d = dly[win_d*N +: N];
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            ptr_q   <= IW'(R - 1);
            idx_q   <= '0;
            tgt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        idx_q   <= win_d;
                        tgt_q   <= tgt_d;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: state_q <= COUNT;
                COUNT: begin
                    if (cnt_val == tgt_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ptr_q   <= idx_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        own     = R'(1) << idx_q;
        busy    = (state_q != IDLE);
        gnt     = busy ? own : '0;
        done    = (state_q == DONE) ? own : '0;
        cnt_en  = (state_q == COUNT) && (cnt_val != tgt_q);
        cnt_clr = ~clr | (state_q == CLEAR);
    end

endmodule
`default_nettype wire

// File: tb/tb_upcount_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_upcount_sched
// Description : Self-checking bench for upcount_sched with a behavioural
//               counter and an interval-offset reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upcount_sched;

    localparam int N = 4;
    localparam int R = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic [R-1:0]     req = '0;
    logic [R*N-1:0]   dly = '0;
    logic [R-1:0]     gnt;
    logic [R-1:0]     done;
    logic             busy;
    logic             cnt_clr;
    logic             cnt_en;
    logic [N-1:0]     cnt_val = '0;
    logic [2*R+2:0]   obs;

    int n_vec = 0;
    int n_err = 0;

    // Reference: an active interval is described by owner, target and the
    // number of cycles elapsed since the grant (1 = clear cycle).
    bit m_act = 1'b0;
    int m_own = 0;
    int m_tgt = 0;
    int m_off = 0;
    int m_ptr = R - 1;

    upcount_sched #(.N(N), .R(R)) dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .dly     (dly),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .cnt_val (cnt_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr)     cnt_val <= '0;
        else if (cnt_en) cnt_val <= cnt_val + 1'b1;
    end

    assign obs = {gnt, done, busy, cnt_en, cnt_clr};

    task automatic model_step();
        if (!clr) begin
            m_act = 1'b0;
            m_ptr = R - 1;
        end else if (m_act) begin
            if (m_off == m_tgt + 3) begin
                m_act = 1'b0;
                m_ptr = m_own;
            end else begin
                m_off++;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= R; k++) begin
                int j;
                j = (m_ptr + k) % R;
                if (req[j]) begin
                    m_own = j;
                    break;
                end
            end
            m_tgt = int'(dly[m_own*N +: N]);
            m_off = 1;
            m_act = 1'b1;
        end
    endtask

    function automatic logic [2*R+2:0] exp_vec();
        logic [R-1:0] g;
        logic [R-1:0] d;
        logic         e;
        logic         c;
        g = m_act ? (R'(1) << m_own) : '0;
        d = (m_act && m_off == m_tgt + 3) ? g : '0;
        e = m_act && m_off >= 2 && m_off <= m_tgt + 1;
        c = !clr || (m_act && m_off == 1);
        return {g, d, m_act, e, c};
    endfunction

    function automatic bit cnt_known();
        return m_act && m_off >= 2;
    endfunction

    function automatic int exp_cnt();
        return (m_off - 2 < m_tgt) ? m_off - 2 : m_tgt;
    endfunction

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0;
        req = '0;
        advance();
        advance();
        n_vec++;
        if ({gnt, done, busy, cnt_en, cnt_clr} !== {4'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", obs, {4'b0, 4'b0, 3'b001});
        end
        clr = 1'b1;
        advance();
        n_vec++;
        if (cnt_clr !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: cnt_clr=%b busy=%b want 0 0", cnt_clr, busy);
        end
    endtask

    task automatic test_single();
        int en_cyc = 0;
        int done_at = -1;
        logic [N-1:0] seq[$];
        dly = '0;
        dly[3:0] = 4'd5;
        req = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            advance();
            req = '0;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL single c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
            if (cnt_known()) begin
                n_vec++;
                if (cnt_val !== N'(exp_cnt())) begin
                    n_err++;
                    $display("FAIL single_cnt c%0d: got %0d want %0d", k, cnt_val, exp_cnt());
                end
            end
            if (cnt_en) en_cyc++;
            if (k >= 2 && k <= 7) seq.push_back(cnt_val);
            if (done != '0 && done_at < 0) done_at = k;
            if (k == 1) begin
                n_vec++;
                if (gnt !== 4'b0001) begin
                    n_err++;
                    $display("FAIL single_gnt: got %b want 0001", gnt);
                end
            end
            if (k == 8) begin
                n_vec++;
                if (done !== 4'b0001) begin
                    n_err++;
                    $display("FAIL single_done: got %b want 0001", done);
                end
            end
            if (k == 9) begin
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_busy: got %b want 0", busy);
                end
            end
        end
        n_vec++;
        if (en_cyc != 5 || done_at != 8) begin
            n_err++;
            $display("FAIL single_timing: en_cycles=%0d done_at=%0d want 5 8", en_cyc, done_at);
        end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (seq[i] !== N'(i)) begin
                n_err++;
                $display("FAIL single_seq[%0d]: got %0d want %0d", i, seq[i], i);
            end
        end
    endtask

    task automatic test_zero();
        int en_cyc = 0;
        dly = 16'hA7A7;
        dly[2*N +: N] = 4'd0;
        req = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            advance();
            req = '0;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL zero c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
            if (cnt_en) en_cyc++;
            if (k == 3) begin
                n_vec++;
                if (done !== 4'b0100) begin
                    n_err++;
                    $display("FAIL zero_done: got %b want 0100", done);
                end
            end
        end
        n_vec++;
        if (en_cyc != 0) begin
            n_err++;
            $display("FAIL zero_en: cnt_en cycles %0d want 0", en_cyc);
        end
    endtask

    task automatic test_round_robin();
        logic [R-1:0] order[$];
        int starts[$];
        logic [R-1:0] prev_g = '0;
        int idle_cyc = 0;
        logic [R-1:0] want[5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        clr = 1'b0;
        advance();
        clr = 1'b1;
        req = 4'b1111;
        dly = 16'h1111;
        for (int k = 1; k <= 28; k++) begin
            advance();
            if (k == 22) req = '0;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL rr c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
            if (prev_g == '0 && gnt != '0) begin
                order.push_back(gnt);
                starts.push_back(k);
            end
            if (k <= 21 && gnt == '0) idle_cyc++;
            prev_g = gnt;
        end
        n_vec++;
        if (order.size() != 5 || idle_cyc != 4) begin
            n_err++;
            $display("FAIL rr_count: grants=%0d idle=%0d want 5 4", order.size(), idle_cyc);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (order[i] !== want[i] || starts[i] != 1 + 5 * i) begin
                    n_err++;
                    $display("FAIL rr_grant[%0d]: got %b at %0d want %b at %0d",
                             i, order[i], starts[i], want[i], 1 + 5 * i);
                end
            end
        end
    endtask

    task automatic test_late_dly();
        logic [N-1:0] peak = '0;
        dly = '0;
        dly[1*N +: N] = 4'd3;
        req = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            advance();
            req = '0;
            dly[1*N +: N] = 4'd9;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL late c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
            if (k >= 2 && cnt_val > peak) peak = cnt_val;
            if (k == 6) begin
                n_vec++;
                if (done !== 4'b0010 || cnt_val !== 4'd3) begin
                    n_err++;
                    $display("FAIL late_done: done=%b cnt=%0d want 0010 3", done, cnt_val);
                end
            end
        end
        n_vec++;
        if (peak !== 4'd3) begin
            n_err++;
            $display("FAIL late_peak: got %0d want 3", peak);
        end
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        dly = '0;
        dly[0 +: N] = 4'd6;
        dly[1*N +: N] = 4'd2;
        req = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            advance();
            req = '0;
        end
        n_vec++;
        if (cnt_val !== 4'd2 || cnt_en !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre: cnt=%0d en=%b want 2 1", cnt_val, cnt_en);
        end
        clr = 1'b0;
        req = 4'b1010;
        for (int k = 1; k <= 2; k++) begin
            advance();
            if (done != '0) dn++;
            n_vec++;
            if ({gnt, busy, cnt_clr, cnt_en} !== {4'b0000, 1'b0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL rmid_hold c%0d: gnt=%b busy=%b clr=%b en=%b want 0000 0 1 0",
                         k, gnt, busy, cnt_clr, cnt_en);
            end
        end
        clr = 1'b1;
        advance();
        req = '0;
        n_vec++;
        if (gnt !== 4'b0010 || dn != 0) begin
            n_err++;
            $display("FAIL rmid_first: gnt=%b dones=%0d want 0010 0", gnt, dn);
        end
        for (int k = 2; k <= 7; k++) begin
            advance();
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL rmid c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
        end
    endtask

    task automatic test_max();
        int done_at = -1;
        dly = '0;
        dly[0 +: N] = 4'd15;
        req = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            advance();
            req = '0;
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL max c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
            if (done != '0 && done_at < 0) done_at = k;
            if (k == 17 || k == 18) begin
                n_vec++;
                if (cnt_val !== 4'd15) begin
                    n_err++;
                    $display("FAIL max_cnt c%0d: got %0d want 15", k, cnt_val);
                end
            end
        end
        n_vec++;
        if (done_at != 18) begin
            n_err++;
            $display("FAIL max_done: at %0d want 18", done_at);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            clr = ($urandom_range(0, 59) != 0);
            req = ($urandom_range(0, 9) < 3) ? '0 : R'($urandom_range(0, 15));
            dly = (N*R)'($urandom);
            if ($urandom_range(0, 1) == 1) dly = dly & 16'h3333;
            advance();
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL rand c%0d: outputs got %h want %h", k, obs, exp_vec());
            end
            if (cnt_known()) begin
                n_vec++;
                if (cnt_val !== N'(exp_cnt())) begin
                    n_err++;
                    $display("FAIL rand_cnt c%0d: got %0d want %0d", k, cnt_val, exp_cnt());
                end
            end
        end
        clr = 1'b1;
        req = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_late_dly();
        test_reset_mid();
        test_max();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
